// File: rtl/tram_console_pkg.sv
// rtl/tram_console_pkg.sv - control codes and FSM encoding for tram_console.
// TRAM_CONSOLE_SCROLL_EN adds the scroll states to the encoding.
package tram_console_pkg;

  localparam logic [7:0] CODE_LF    = 8'h0A;
  localparam logic [7:0] CODE_CR    = 8'h0D;
  localparam logic [7:0] CODE_BS    = 8'h08;
  localparam logic [7:0] CODE_FF    = 8'h0C;
  localparam logic [7:0] CODE_SPACE = 8'h20;
  localparam logic [7:0] CODE_TILDE = 8'h7E;

`ifdef TRAM_CONSOLE_SCROLL_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUT     = 3'd1,
    SCRL_RD = 3'd2,
    SCRL_WR = 3'd3,
    CLR     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUT     = 3'd1,
    CLR     = 3'd4
  } state_t;
`endif

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= CODE_SPACE) && (code <= CODE_TILDE);
  endfunction

endpackage

// File: rtl/tram_console_if.sv
// rtl/tram_console_if.sv - character stream into tram_console.
// master offers characters, slave (the console) accepts them.
interface tram_console_if #(
  parameter int BYTE = 8,
  parameter int WORD = 32
) ();

  logic                 ch_valid;
  logic                 ch_ready;
  logic [BYTE-1:0]      ch_data;
  logic [WORD-BYTE-1:0] ch_attr;

  modport master (
    output ch_valid,
    output ch_data,
    output ch_attr,
    input  ch_ready
  );

  modport slave (
    input  ch_valid,
    input  ch_data,
    input  ch_attr,
    output ch_ready
  );

endinterface

// File: rtl/tram_console.sv
// rtl/tram_console.sv - text console writing characters into a text RAM with cursor, clear and
// optional scroll (TRAM_CONSOLE_SCROLL_EN).
module tram_console
  import tram_console_pkg::*;
#(
  parameter int BYTE     = 8,
  parameter int BYTE_CNT = 4,
  parameter int WORD     = 32,
  parameter int ADDRW    = 12,
  parameter int COLS     = 80,
  parameter int ROWS     = 30,
  localparam int CW      = $clog2(COLS),
  localparam int RW      = $clog2(ROWS)
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  tram_console_if.slave       ch,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  input  logic [WORD-1:0]     tram_dout,
  output logic [CW-1:0]       cur_col,
  output logic [RW-1:0]       cur_row
);

  localparam logic [CW-1:0]       COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]       ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDRW-1:0]    ADDR_COLS = ADDRW'(COLS);
  localparam logic [ADDRW-1:0]    ADDR_LAST = ADDRW'(COLS * ROWS - 1);
  localparam logic [WORD-1:0]     BLANK     = WORD'(CODE_SPACE);
  localparam logic [BYTE_CNT-1:0] WE_ALL    = '1;

  state_t           state;
  logic             ready_q;
  logic [WORD-1:0]  din_q;
  logic [ADDRW-1:0] cur_addr;
  logic             clr_home;

  logic [7:0]       code;
  logic [ADDRW-1:0] row_base;
  logic [CW-1:0]    nxt_col;
  logic [RW-1:0]    nxt_row;
  logic [ADDRW-1:0] nxt_addr;
  logic             newline;

`ifdef TRAM_CONSOLE_SCROLL_EN
  localparam logic [ADDRW-1:0] ADDR_LAST_ROW = ADDRW'(COLS * (ROWS - 1));
  logic [ADDRW-1:0] src;
  logic             scrl_pend;
  logic             nxt_scroll;

  // Copy data flows straight from the RAM read port in the write half of each copy pair.
  assign tram_din = (state == SCRL_WR) ? tram_dout : din_q;
`else
  logic unused_dout;
  assign unused_dout = ^tram_dout;
  assign tram_din    = din_q;
`endif

  assign code     = ch.ch_data[7:0];
  assign ch.ch_ready = ready_q;

  // Cursor position the accepted character would leave behind; the address tracks row*COLS+col.
  always_comb begin
    row_base = cur_addr - ADDRW'(cur_col);
    nxt_col  = cur_col;
    nxt_row  = cur_row;
    nxt_addr = cur_addr;
    newline  = 1'b0;
`ifdef TRAM_CONSOLE_SCROLL_EN
    nxt_scroll = 1'b0;
`endif
    if (is_printable(code)) begin
      if (cur_col != COL_LAST) begin
        nxt_col  = cur_col + CW'(1);
        nxt_addr = cur_addr + ADDRW'(1);
      end else begin
        newline = 1'b1;
      end
    end else begin
      case (code)
        CODE_LF: newline = 1'b1;
        CODE_CR: begin
          nxt_col  = '0;
          nxt_addr = row_base;
        end
        CODE_BS: begin
          if (cur_col != '0) begin
            nxt_col  = cur_col - CW'(1);
            nxt_addr = cur_addr - ADDRW'(1);
          end
        end
        default: ;
      endcase
    end
    if (newline) begin
      nxt_col = '0;
      if (cur_row != ROW_LAST) begin
        nxt_row  = cur_row + RW'(1);
        nxt_addr = row_base + ADDR_COLS;
      end else begin
`ifdef TRAM_CONSOLE_SCROLL_EN
        nxt_addr   = row_base;
        nxt_scroll = 1'b1;
`else
        nxt_row  = '0;
        nxt_addr = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      tram_we   <= '0;
      tram_addr <= '0;
      din_q     <= '0;
      cur_col   <= '0;
      cur_row   <= '0;
      cur_addr  <= '0;
      clr_home  <= 1'b0;
`ifdef TRAM_CONSOLE_SCROLL_EN
      src       <= '0;
      scrl_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (ch.ch_valid && ready_q) begin
            cur_col  <= nxt_col;
            cur_row  <= nxt_row;
            cur_addr <= nxt_addr;
            if (is_printable(code)) begin
              state     <= PUT;
              ready_q   <= 1'b0;
              tram_we   <= WE_ALL;
              tram_addr <= cur_addr;
              din_q     <= {ch.ch_attr, ch.ch_data};
`ifdef TRAM_CONSOLE_SCROLL_EN
              scrl_pend <= nxt_scroll;
`endif
            end else if (code == CODE_FF) begin
              state     <= CLR;
              ready_q   <= 1'b0;
              tram_we   <= WE_ALL;
              tram_addr <= '0;
              din_q     <= BLANK;
              clr_home  <= 1'b1;
            end
`ifdef TRAM_CONSOLE_SCROLL_EN
            else if (nxt_scroll) begin
              state     <= SCRL_RD;
              ready_q   <= 1'b0;
              tram_addr <= ADDR_COLS;
              src       <= ADDR_COLS;
            end
`endif
          end
        end

        PUT: begin
          tram_we <= '0;
`ifdef TRAM_CONSOLE_SCROLL_EN
          if (scrl_pend) begin
            scrl_pend <= 1'b0;
            state     <= SCRL_RD;
            tram_addr <= ADDR_COLS;
            src       <= ADDR_COLS;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
`else
          state   <= IDLE;
          ready_q <= 1'b1;
`endif
        end

`ifdef TRAM_CONSOLE_SCROLL_EN
        SCRL_RD: begin
          state     <= SCRL_WR;
          tram_we   <= WE_ALL;
          tram_addr <= src - ADDR_COLS;
        end

        SCRL_WR: begin
          if (src == ADDR_LAST) begin
            // Copy done: blank the last row through the clear path without homing.
            state     <= CLR;
            tram_addr <= ADDR_LAST_ROW;
            din_q     <= BLANK;
          end else begin
            state     <= SCRL_RD;
            tram_we   <= '0;
            src       <= src + ADDRW'(1);
            tram_addr <= src + ADDRW'(1);
          end
        end
`endif

        CLR: begin
          if (tram_addr == ADDR_LAST) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            tram_we  <= '0;
            clr_home <= 1'b0;
            if (clr_home) begin
              cur_col  <= '0;
              cur_row  <= '0;
              cur_addr <= '0;
            end
          end else begin
            tram_addr <= tram_addr + ADDRW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          tram_we <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tram_console.sv
// tb/tb_tram_console.sv - table-driven bench for tram_console on a 4x3 screen with a
// 1-cycle-latency text RAM model; expectations follow TRAM_CONSOLE_SCROLL_EN.
module tb_tram_console;

  localparam int COLS = 4;
  localparam int ROWS = 3;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic [3:0]  tram_we;
  logic [11:0] tram_addr;
  logic [31:0] tram_din;
  logic [31:0] tram_dout;
  logic [1:0]  cur_col;
  logic [1:0]  cur_row;

  logic [31:0] mem [0:15];
  int          wr_cnt = 0;
  int          n_vec  = 0;
  int          n_miss = 0;

  tram_console_if #(.BYTE(8), .WORD(32)) ch_if ();

  tram_console #(
    .BYTE(8), .BYTE_CNT(4), .WORD(32), .ADDRW(12), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .ch        (ch_if.slave),
    .tram_we   (tram_we),
    .tram_addr (tram_addr),
    .tram_din  (tram_din),
    .tram_dout (tram_dout),
    .cur_col   (cur_col),
    .cur_row   (cur_row)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    tram_dout = 32'h0;
  end

  always @(posedge clk_sys) begin
    if (tram_we != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (tram_we[b]) mem[tram_addr[3:0]][8*b +: 8] <= tram_din[8*b +: 8];
      wr_cnt <= wr_cnt + 1;
    end else begin
      tram_dout <= mem[tram_addr[3:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!ch_if.ch_ready && guard < 200) begin
      @(negedge clk_sys);
      guard++;
    end
    check("ready wait", {31'b0, ch_if.ch_ready}, 32'd1);
  endtask

  // Offer one character; report how many cycles ch_ready stayed low afterwards.
  task automatic send(input logic [7:0] d, input logic [23:0] a, output int low);
    wait_ready();
    ch_if.ch_valid = 1'b1;
    ch_if.ch_data  = d;
    ch_if.ch_attr  = a;
    @(negedge clk_sys);
    ch_if.ch_valid = 1'b0;
    low = 0;
    while (!ch_if.ch_ready && low < 200) begin
      low++;
      @(negedge clk_sys);
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [23:0] a;
    int          col;
    int          row;
    int          low;
    int          nwr;
    int          waddr;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    int low;
    int w0;
    logic [7:0] c;

    vecs[0]  = '{8'h41, 24'h00AB00, 1, 0, 1, 1, 0, 32'h00AB0041};
    vecs[1]  = '{8'h0D, 24'h000000, 0, 0, 0, 0, 0, 32'h0};
    vecs[2]  = '{8'h77, 24'h000001, 1, 0, 1, 1, 0, 32'h00000177};
    vecs[3]  = '{8'h78, 24'h000002, 2, 0, 1, 1, 1, 32'h00000278};
    vecs[4]  = '{8'h79, 24'h000003, 3, 0, 1, 1, 2, 32'h00000379};
    vecs[5]  = '{8'h7A, 24'h000004, 0, 1, 1, 1, 3, 32'h0000047A};
    vecs[6]  = '{8'h08, 24'h000000, 0, 1, 0, 0, 0, 32'h0};
    vecs[7]  = '{8'h71, 24'h123456, 1, 1, 1, 1, 4, 32'h12345671};
    vecs[8]  = '{8'h08, 24'h000000, 0, 1, 0, 0, 0, 32'h0};
    vecs[9]  = '{8'h0A, 24'h000000, 0, 2, 0, 0, 0, 32'h0};
    vecs[10] = '{8'h07, 24'h000000, 0, 2, 0, 0, 0, 32'h0};
    vecs[11] = '{8'h7E, 24'h000000, 1, 2, 1, 1, 8, 32'h0000007E};
    vecs[12] = '{8'h7F, 24'h000000, 1, 2, 0, 0, 0, 32'h0};
    vecs[13] = '{8'h1F, 24'h000000, 1, 2, 0, 0, 0, 32'h0};
    vecs[14] = '{8'h20, 24'h0000FF, 2, 2, 1, 1, 9, 32'h0000FF20};
    vecs[15] = '{8'h0D, 24'h000000, 0, 2, 0, 0, 0, 32'h0};

    ch_if.ch_valid = 1'b0;
    ch_if.ch_data  = 8'h0;
    ch_if.ch_attr  = 24'h0;
    rst_sys_n      = 1'b0;
    repeat (3) @(negedge clk_sys);

    check("rst ready", {31'b0, ch_if.ch_ready}, 32'd0);
    check("rst we", {28'b0, tram_we}, 32'd0);
    check("rst addr", {20'b0, tram_addr}, 32'd0);
    check("rst din", tram_din, 32'd0);
    check("rst col", {30'b0, cur_col}, 32'd0);
    check("rst row", {30'b0, cur_row}, 32'd0);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    check("ready after release", {31'b0, ch_if.ch_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      w0 = wr_cnt;
      send(vecs[i].d, vecs[i].a, low);
      check($sformatf("v%0d col", i), {30'b0, cur_col}, 32'(vecs[i].col));
      check($sformatf("v%0d row", i), {30'b0, cur_row}, 32'(vecs[i].row));
      check($sformatf("v%0d busy", i), 32'(low), 32'(vecs[i].low));
      check($sformatf("v%0d writes", i), 32'(wr_cnt - w0), 32'(vecs[i].nwr));
      if (vecs[i].nwr != 0)
        check($sformatf("v%0d ram", i), mem[vecs[i].waddr], vecs[i].wdata);
    end

    // Form feed clears the whole screen and homes; backspace at column 0 is inert.
    w0 = wr_cnt;
    send(8'h0C, 24'h0, low);
    check("ff busy", 32'(low), 32'd12);
    check("ff writes", 32'(wr_cnt - w0), 32'd12);
    check("ff col", {30'b0, cur_col}, 32'd0);
    check("ff row", {30'b0, cur_row}, 32'd0);
    for (int j = 0; j < 12; j++) check($sformatf("ff ram%0d", j), mem[j], 32'h00000020);
    w0 = wr_cnt;
    send(8'h08, 24'h0, low);
    check("bs0 writes", 32'(wr_cnt - w0), 32'd0);
    check("bs0 busy", 32'(low), 32'd0);
    check("bs0 col", {30'b0, cur_col}, 32'd0);

    // Fill the screen; the last character wraps off the bottom row.
    w0 = wr_cnt;
    for (int j = 0; j < 12; j++) begin
      c = 8'h61 + 8'(j);
      send(c, 24'h0, low);
    end
`ifdef TRAM_CONSOLE_SCROLL_EN
    check("fill last busy", 32'(low), 32'd21);
    check("fill writes", 32'(wr_cnt - w0), 32'd24);
    check("fill col", {30'b0, cur_col}, 32'd0);
    check("fill row", {30'b0, cur_row}, 32'd2);
    for (int j = 0; j < 8; j++) check($sformatf("fill ram%0d", j), mem[j], 32'h65 + 32'(j));
    for (int j = 8; j < 12; j++) check($sformatf("fill ram%0d", j), mem[j], 32'h20);

    w0 = wr_cnt;
    send(8'h0A, 24'h0, low);
    check("lf scroll busy", 32'(low), 32'd20);
    check("lf scroll writes", 32'(wr_cnt - w0), 32'd12);
    check("lf scroll col", {30'b0, cur_col}, 32'd0);
    check("lf scroll row", {30'b0, cur_row}, 32'd2);
    for (int j = 0; j < 4; j++) check($sformatf("lf ram%0d", j), mem[j], 32'h69 + 32'(j));
    for (int j = 4; j < 12; j++) check($sformatf("lf ram%0d", j), mem[j], 32'h20);
`else
    check("fill last busy", 32'(low), 32'd1);
    check("fill writes", 32'(wr_cnt - w0), 32'd12);
    check("fill col", {30'b0, cur_col}, 32'd0);
    check("fill row", {30'b0, cur_row}, 32'd0);
    send(8'h0A, 24'h0, low);
    send(8'h0A, 24'h0, low);
    check("lf row2", {30'b0, cur_row}, 32'd2);
    w0 = wr_cnt;
    send(8'h0A, 24'h0, low);
    check("lf wrap busy", 32'(low), 32'd0);
    check("lf wrap writes", 32'(wr_cnt - w0), 32'd0);
    check("lf wrap col", {30'b0, cur_col}, 32'd0);
    check("lf wrap row", {30'b0, cur_row}, 32'd0);
    for (int j = 0; j < 12; j++) check($sformatf("lf ram%0d", j), mem[j], 32'h61 + 32'(j));
`endif

    // Reset five cycles into a long operation (scroll if built, otherwise clear).
    wait_ready();
    ch_if.ch_valid = 1'b1;
`ifdef TRAM_CONSOLE_SCROLL_EN
    ch_if.ch_data = 8'h0A;
`else
    ch_if.ch_data = 8'h0C;
`endif
    @(negedge clk_sys);
    ch_if.ch_valid = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("mid busy", {31'b0, ch_if.ch_ready}, 32'd0);
`ifdef TRAM_CONSOLE_SCROLL_EN
    check("mid addr", {20'b0, tram_addr}, 32'd6);
    check("mid we", {28'b0, tram_we}, 32'd0);
`else
    check("mid addr", {20'b0, tram_addr}, 32'd4);
    check("mid we", {28'b0, tram_we}, 32'hF);
`endif
    rst_sys_n = 1'b0;
    #1;
    check("mid rst we", {28'b0, tram_we}, 32'd0);
    check("mid rst addr", {20'b0, tram_addr}, 32'd0);
    check("mid rst din", tram_din, 32'd0);
    check("mid rst col", {30'b0, cur_col}, 32'd0);
    check("mid rst row", {30'b0, cur_row}, 32'd0);
    check("mid rst ready", {31'b0, ch_if.ch_ready}, 32'd0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    check("release ready low", {31'b0, ch_if.ch_ready}, 32'd0);
    @(negedge clk_sys);
    check("release ready high", {31'b0, ch_if.ch_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
